// File: rtl/store_check_monitor.sv
// Store-bus checker: classifies core data-memory writes against a loadable
// table of expected values and reports saturating counters plus a verdict.
module store_check_monitor #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int NUM_CHECKS = 9,
  parameter int BASE_ADDR  = 200,
  parameter int STRIDE     = 4,
  parameter int TIMEOUT    = 64,
  parameter bit ORDERED    = 1'b0,
  parameter int CNT_W      = 8,
  localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  unexp_cnt,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic              first_fail_vld,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic              pass
);
  localparam int SH   = (STRIDE > 1) ? $clog2(STRIDE) : 0;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W:0]  NUM_L = NUM_CHECKS[IDX_W:0];
  localparam logic [CNT_W-1:0] NUM_C = NUM_CHECKS[CNT_W-1:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state, w_state_nxt;
  logic [NUM_CHECKS-1:0][DATA_W-1:0] r_tbl;
  logic [NUM_CHECKS-1:0] r_chk, w_chk_nxt;
  logic [IDX_W-1:0]  r_nxt, w_nxt_nxt, r_ffi, w_ffi_nxt;
  logic [CNT_W-1:0]  r_pc, w_pc_nxt, r_fc, w_fc_nxt, r_uc, w_uc_nxt;
  logic [WD_W-1:0]   r_wd, w_wd_nxt;
  logic              r_ffv, w_ffv_nxt, r_to, w_to_nxt, r_pass, w_pass_nxt;

  logic [ADDR_W-1:0] w_off, w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_inwin, w_clr, w_wd_hit, w_all;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Address decode: modulo subtraction makes below-base addresses wrap high.
  assign w_off      = dataadr - ADDR_W'(BASE_ADDR);
  assign w_idx_full = w_off >> SH;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_inwin    = ~|(w_off & ADDR_W'(STRIDE - 1)) &
                      (w_idx_full < ADDR_W'(NUM_CHECKS));
  assign w_clr      = start & (r_state != S_RUN);
  assign w_wd_hit   = (r_wd == WD_W'(TIMEOUT - 1));
  assign w_all      = &w_chk_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_all || w_wd_hit) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_chk_nxt = r_chk;
    w_nxt_nxt = r_nxt;
    w_pc_nxt  = r_pc;
    w_fc_nxt  = r_fc;
    w_uc_nxt  = r_uc;
    w_ffi_nxt = r_ffi;
    w_ffv_nxt = r_ffv;
    w_to_nxt  = r_to;
    w_wd_nxt  = r_wd;
    if (w_clr) begin
      w_chk_nxt = '0;
      w_nxt_nxt = '0;
      w_pc_nxt  = '0;
      w_fc_nxt  = '0;
      w_uc_nxt  = '0;
      w_ffi_nxt = '0;
      w_ffv_nxt = 1'b0;
      w_to_nxt  = 1'b0;
      w_wd_nxt  = '0;
    end else if (r_state == S_RUN) begin
      w_wd_nxt = r_wd + 1'b1;
      if (memwrite) begin
        if (!w_inwin) begin
          w_uc_nxt = sat_inc(r_uc);
          w_fc_nxt = sat_inc(r_fc);
        end else if (r_chk[w_idx]) begin
          w_fc_nxt = sat_inc(r_fc);
        end else if (ORDERED && (w_idx != r_nxt)) begin
          w_fc_nxt         = sat_inc(r_fc);
          w_chk_nxt[w_idx] = 1'b1;
        end else begin
          w_chk_nxt[w_idx] = 1'b1;
          w_nxt_nxt        = r_nxt + 1'b1;
          if (writedata == r_tbl[w_idx]) w_pc_nxt = sat_inc(r_pc);
          else                           w_fc_nxt = sat_inc(r_fc);
        end
        // Only in-window failures carry an index worth reporting.
        if (w_inwin && (w_fc_nxt != r_fc || &r_fc) && !r_ffv &&
            !(w_pc_nxt != r_pc || (&r_pc && writedata == r_tbl[w_idx] &&
              !r_chk[w_idx] && !(ORDERED && w_idx != r_nxt)))) begin
          w_ffv_nxt = 1'b1;
          w_ffi_nxt = w_idx;
        end
      end
      if (!w_all && w_wd_hit) w_to_nxt = 1'b1;
    end
    w_pass_nxt = (w_state_nxt == S_DONE) & ~w_to_nxt &
                 (w_fc_nxt == '0) & (w_pc_nxt == NUM_C);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tbl  <= '0;
      r_chk  <= '0;
      r_nxt  <= '0;
      r_pc   <= '0;
      r_fc   <= '0;
      r_uc   <= '0;
      r_ffi  <= '0;
      r_ffv  <= 1'b0;
      r_to   <= 1'b0;
      r_wd   <= '0;
      r_pass <= 1'b0;
    end else begin
      if (r_state == S_IDLE && exp_we && ({1'b0, exp_idx} < NUM_L))
        r_tbl[exp_idx] <= exp_data;
      r_chk  <= w_chk_nxt;
      r_nxt  <= w_nxt_nxt;
      r_pc   <= w_pc_nxt;
      r_fc   <= w_fc_nxt;
      r_uc   <= w_uc_nxt;
      r_ffi  <= w_ffi_nxt;
      r_ffv  <= w_ffv_nxt;
      r_to   <= w_to_nxt;
      r_wd   <= w_wd_nxt;
      r_pass <= w_pass_nxt;
    end
  end

  assign pass_cnt       = r_pc;
  assign fail_cnt       = r_fc;
  assign unexp_cnt      = r_uc;
  assign first_fail_idx = r_ffi;
  assign first_fail_vld = r_ffv;
  assign busy           = (r_state == S_RUN);
  assign done           = (r_state == S_DONE);
  assign timed_out      = r_to;
  assign pass           = r_pass;
endmodule

// File: tb/tb_store_check_monitor.sv
// Bench: unordered (CNT_W=8) and ordered (CNT_W=4) checkers share stimulus and
// are compared every cycle against an arithmetic reference model.
module tb_store_check_monitor;
  localparam int NC = 9, BASE = 200, TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, exp_we, start, memwrite;
  logic [3:0]  exp_idx;
  logic [31:0] exp_data, dataadr, writedata;

  logic [7:0] pc0, fc0, uc0;
  logic [3:0] pc1, fc1, uc1, ffi0, ffi1;
  logic       ffv0, busy0, done0, to0, pass0;
  logic       ffv1, busy1, done1, to1, pass1;

  store_check_monitor #(.ORDERED(1'b0), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .pass_cnt(pc0), .fail_cnt(fc0), .unexp_cnt(uc0), .first_fail_idx(ffi0),
    .first_fail_vld(ffv0), .busy(busy0), .done(done0), .timed_out(to0), .pass(pass0));

  store_check_monitor #(.ORDERED(1'b1), .CNT_W(4)) u_dut_o (
    .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .pass_cnt(pc1), .fail_cnt(fc1), .unexp_cnt(uc1), .first_fail_idx(ffi1),
    .first_fail_vld(ffv1), .busy(busy1), .done(done1), .timed_out(to1), .pass(pass1));

  int total = 0, bad = 0, cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = unordered/8-bit, 1 = ordered/4-bit.
  logic [31:0] m_tbl [2][NC];
  bit          m_chk [2][NC];
  int m_st[2], m_pc[2], m_fc[2], m_uc[2], m_ffi[2], m_nxt[2], m_wd[2];
  bit m_ffv[2], m_to[2];

  function automatic int maxc(input int m);
    return (m == 1) ? 15 : 255;
  endfunction

  task automatic m_clear(input int m);
    m_pc[m] = 0; m_fc[m] = 0; m_uc[m] = 0; m_ffi[m] = 0; m_nxt[m] = 0; m_wd[m] = 0;
    m_ffv[m] = 0; m_to[m] = 0;
    for (int i = 0; i < NC; i++) m_chk[m][i] = 0;
  endtask

  task automatic m_fail(input int m, input int idx, input bit has_idx);
    if (m_fc[m] < maxc(m)) m_fc[m]++;
    if (has_idx && !m_ffv[m]) begin m_ffv[m] = 1; m_ffi[m] = idx; end
  endtask

  task automatic model_step();
    logic [31:0] off;
    int i;
    bit all;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_clear(m);
        m_st[m] = 0;
        for (int k = 0; k < NC; k++) m_tbl[m][k] = 0;
      end else if (m_st[m] == 0 || m_st[m] == 2) begin
        if (m_st[m] == 0 && exp_we && exp_idx < NC) m_tbl[m][exp_idx] = exp_data;
        if (start) begin m_clear(m); m_st[m] = 1; end
      end else begin
        if (memwrite) begin
          off = dataadr - 32'(BASE);
          if (off % 4 != 0 || off / 4 >= NC) begin
            if (m_uc[m] < maxc(m)) m_uc[m]++;
            m_fail(m, 0, 0);
          end else begin
            i = int'(off / 4);
            if (m_chk[m][i]) m_fail(m, i, 1);
            else if (m == 1 && i != m_nxt[m]) begin
              m_chk[m][i] = 1;
              m_fail(m, i, 1);
            end else begin
              m_chk[m][i] = 1;
              m_nxt[m]++;
              if (writedata == m_tbl[m][i]) begin
                if (m_pc[m] < maxc(m)) m_pc[m]++;
              end else m_fail(m, i, 1);
            end
          end
        end
        m_wd[m]++;
        all = 1;
        for (int k = 0; k < NC; k++) all &= m_chk[m][k];
        if (all) m_st[m] = 2;
        else if (m_wd[m] >= TO) begin m_st[m] = 2; m_to[m] = 1; end
      end
    end
  endtask

  function automatic logic [31:0] m_pass(input int m);
    return 32'(m_st[m] == 2 && !m_to[m] && m_fc[m] == 0 && m_pc[m] == NC);
  endfunction

  task automatic compare_all();
    chk("busy0", 32'(busy0), 32'(m_st[0] == 1));
    chk("done0", 32'(done0), 32'(m_st[0] == 2));
    chk("pc0",   32'(pc0),   32'(m_pc[0]));
    chk("fc0",   32'(fc0),   32'(m_fc[0]));
    chk("uc0",   32'(uc0),   32'(m_uc[0]));
    chk("ffv0",  32'(ffv0),  32'(m_ffv[0]));
    chk("ffi0",  32'(ffi0),  32'(m_ffi[0]));
    chk("to0",   32'(to0),   32'(m_to[0]));
    chk("pass0", 32'(pass0), m_pass(0));
    chk("busy1", 32'(busy1), 32'(m_st[1] == 1));
    chk("done1", 32'(done1), 32'(m_st[1] == 2));
    chk("pc1",   32'(pc1),   32'(m_pc[1]));
    chk("fc1",   32'(fc1),   32'(m_fc[1]));
    chk("uc1",   32'(uc1),   32'(m_uc[1]));
    chk("ffv1",  32'(ffv1),  32'(m_ffv[1]));
    chk("ffi1",  32'(ffi1),  32'(m_ffi[1]));
    chk("to1",   32'(to1),   32'(m_to[1]));
    chk("pass1", 32'(pass1), m_pass(1));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    #1 compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    cyc();
    memwrite = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(done0 && done1) && n < budget) begin cyc(); n++; end
    chk("wait_done", 32'(done0 && done1), 32'd1);
  endtask

  logic [31:0] ivals [NC] = '{32'd300, 32'd1, 32'd1, 32'd96, 32'd244, 32'hFFFFFF9B,
                              32'd1600, 32'd6, 32'hFFFFFFF9};

  task automatic load_ivals();
    for (int i = 0; i < NC; i++) begin
      exp_we = 1'b1; exp_idx = 4'(i); exp_data = ivals[i];
      cyc();
    end
    exp_we = 1'b0;
  endtask

  int c0;
  int r, kind, ai;
  logic [31:0] a, d;

  initial begin
    rst_n = 1'b1; exp_we = 1'b0; start = 1'b0; memwrite = 1'b0;
    exp_idx = '0; exp_data = '0; dataadr = '0; writedata = '0;
    for (int m = 0; m < 2; m++) begin
      m_st[m] = 0; m_clear(m);
      for (int k = 0; k < NC; k++) m_tbl[m][k] = 0;
    end
    do_reset();
    chk("rst_pc", 32'(pc0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);

    // all nine I-type stores match
    load_ivals();
    pulse_start();
    chk("s1_busy", 32'(busy0), 32'd1);
    for (int i = 0; i < NC; i++) do_store(32'(BASE + 4 * i), ivals[i]);
    chk("s1_done", 32'(done0), 32'd1);
    chk("s1_pc", 32'(pc0), 32'd9);
    chk("s1_fc", 32'(fc0), 32'd0);
    chk("s1_pass", 32'(pass0), 32'd1);
    chk("s1_pass_o", 32'(pass1), 32'd1);

    // re-arm from DONE with retained table, last value wrong
    pulse_start();
    for (int i = 0; i < NC; i++)
      do_store(32'(BASE + 4 * i), (i == 8) ? 32'hFFFFFFF8 : ivals[i]);
    chk("s2_fc", 32'(fc0), 32'd1);
    chk("s2_ffi", 32'(ffi0), 32'd8);
    chk("s2_pass", 32'(pass0), 32'd0);

    // unexpected stores then watchdog
    pulse_start();
    c0 = cyc_n;
    do_store(32'd236, 32'd0);
    do_store(32'd202, 32'd0);
    do_store(32'd100, 32'd0);
    chk("s3_uc", 32'(uc0), 32'd3);
    chk("s3_fc", 32'(fc0), 32'd3);
    wait_done(100);
    chk("s3_lat", 32'(cyc_n - c0), 32'd64);
    chk("s3_to", 32'(to0), 32'd1);

    // duplicate
    pulse_start();
    do_store(32'd204, 32'd1);
    do_store(32'd204, 32'd1);
    chk("s4_pc", 32'(pc0), 32'd1);
    chk("s4_fc", 32'(fc0), 32'd1);
    wait_done(100);

    // ordered: 204 before 200
    pulse_start();
    do_store(32'd204, 32'd1);
    do_store(32'd200, 32'd300);
    chk("s5_fc_o", 32'(fc1), 32'd1);
    chk("s5_ffi_o", 32'(ffi1), 32'd1);
    chk("s5_fc_u", 32'(fc0), 32'd0);
    wait_done(100);

    // reset mid-RUN after four passes
    pulse_start();
    for (int i = 0; i < 4; i++) do_store(32'(BASE + 4 * i), ivals[i]);
    chk("s6_pc_pre", 32'(pc0), 32'd4);
    do_reset();
    chk("s6_pc", 32'(pc0), 32'd0);
    chk("s6_busy", 32'(busy0), 32'd0);
    do_store(32'd200, 32'd300);
    chk("s6_idle_pc", 32'(pc0), 32'd0);
    pulse_start();
    do_store(32'd200, 32'd300);
    chk("s6_tbl_clr", 32'(fc0), 32'd1);
    do_reset();

    // randomized rounds
    for (r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      for (int k = 0; k < $urandom_range(0, 12); k++) begin
        exp_we = 1'b1; exp_idx = 4'($urandom_range(0, 15)); exp_data = $urandom_range(0, 3);
        cyc();
      end
      exp_we = $urandom_range(0, 1) == 1; exp_idx = 4'($urandom_range(0, 8));
      exp_data = $urandom_range(0, 3);
      pulse_start();
      exp_we = 1'b0;
      kind = $urandom_range(0, 3);
      for (int k = 0; k < 80 && !(done0 && done1); k++) begin
        memwrite = $urandom_range(0, 9) < 7;
        ai = $urandom_range(0, NC - 1);
        case ((kind == 0) ? 3 : $urandom_range(0, 6))
          3:       a = 32'(BASE - 8 + $urandom_range(0, 50));
          4:       a = $urandom;
          default: a = 32'(BASE + 4 * ai);
        endcase
        d = ($urandom_range(0, 3) != 0) ? m_tbl[0][ai] : 32'($urandom_range(0, 3));
        dataadr = a; writedata = d;
        start = $urandom_range(0, 19) == 0;
        exp_we = $urandom_range(0, 19) == 0;
        exp_idx = 4'(ai); exp_data = $urandom;
        rst_n = $urandom_range(0, 99) != 0;
        cyc();
        rst_n = 1'b1; start = 1'b0; exp_we = 1'b0; memwrite = 1'b0;
      end
      if (!(busy0 || busy1)) chk("rnd_settled", 32'(busy0 | busy1), 32'd0);
      else wait_done(100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
